// File: rtl/spi_master_core_if.sv
// Host-side request/response bundle for spi_master_core.
// The SPI pins stay plain ports on the core.
interface spi_master_core_if #(
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 3
);
   localparam int SS_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   logic              start;
   logic [DATA_W-1:0] data_write;
   logic [SS_W-1:0]   slave_address;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic [DATA_W-1:0] data_read;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, data_write, slave_address, cpol, cpha, lsb_first,
      input  data_read, busy, done, err
   );

   modport slave (
      input  start, data_write, slave_address, cpol, cpha, lsb_first,
      output data_read, busy, done, err
   );
endinterface

// File: rtl/spi_master_core.sv
// SPI master: one word per request, all four CPOL/CPHA modes, MSB/LSB first,
// NUM_SLAVES decoded chip selects, fully registered outputs.
module spi_master_core #(
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 3,
   parameter int CLK_DIV    = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spi_master_core_if.slave      host,
   input  logic                  MISO,
   output logic                  SCLK,
   output logic [NUM_SLAVES-1:0] cs_n,
   output logic                  MOSI
);
   localparam int SS_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2*DATA_W + 1);

   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2*DATA_W - 1);
   localparam logic [EDGE_W-1:0] ALL_EDGES  = EDGE_W'(2*DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic [DATA_W-1:0]     tx_q, tx_d;
   logic [DATA_W-1:0]     rx_q, rx_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic                  lsb_q, lsb_d;
   logic                  sclk_q, sclk_d;
   logic [NUM_SLAVES-1:0] cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic [DATA_W-1:0]     data_read_q, data_read_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  addr_ok;
   logic                  leading;
   logic                  sample_edge;

   function automatic logic [NUM_SLAVES-1:0] decode_cs(input logic [SS_W-1:0] addr);
      logic [NUM_SLAVES-1:0] v;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         v[i] = (addr != SS_W'(i));
      end
      return v;
   endfunction

   assign addr_ok = ({1'b0, host.slave_address} < (SS_W+1)'(NUM_SLAVES));

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      edge_d      = edge_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      mosi_d      = mosi_q;
      data_read_d = data_read_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      leading     = 1'b0;
      sample_edge = 1'b0;

      case (state_q)
         IDLE: begin
            cs_n_d = '1;
            mosi_d = 1'b0;
            sclk_d = cpol_q;
            if (host.start && addr_ok) begin
               state_d = SETUP;
               cnt_d   = CNT_RELOAD;
               edge_d  = '0;
               rx_d    = '0;
               cpol_d  = host.cpol;
               cpha_d  = host.cpha;
               lsb_d   = host.lsb_first;
               sclk_d  = host.cpol;
               cs_n_d  = decode_cs(host.slave_address);
               // With CPHA=0 the slave samples on the first edge, so bit one must be out now.
               if (!host.cpha) begin
                  mosi_d = host.lsb_first ? host.data_write[0] : host.data_write[DATA_W-1];
                  tx_d   = host.lsb_first ? (host.data_write >> 1) : (host.data_write << 1);
               end else begin
                  mosi_d = 1'b0;
                  tx_d   = host.data_write;
               end
            end else if (host.start) begin
               err_d = 1'b1;
            end
         end

         SETUP: begin
            if (cnt_q == '0) begin
               state_d = XFER;
               cnt_d   = CNT_RELOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         XFER: begin
            if (edge_q == ALL_EDGES) begin
               state_d = HOLD;
               cnt_d   = CNT_RELOAD;
            end else if (cnt_q == '0) begin
               cnt_d       = CNT_RELOAD;
               sclk_d      = ~sclk_q;
               edge_d      = edge_q + EDGE_W'(1);
               leading     = ~edge_q[0];
               sample_edge = (leading != cpha_q);
               if (sample_edge) begin
                  rx_d = lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
               end else if (edge_q != LAST_EDGE) begin
                  mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                  tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         HOLD: begin
            sclk_d = cpol_q;
            if (cnt_q == '0) begin
               state_d     = IDLE;
               cs_n_d      = '1;
               mosi_d      = 1'b0;
               data_read_d = rx_q;
               done_d      = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         edge_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         sclk_q      <= 1'b0;
         cs_n_q      <= '1;
         mosi_q      <= 1'b0;
         data_read_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         edge_q      <= edge_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         lsb_q       <= lsb_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         mosi_q      <= mosi_d;
         data_read_q <= data_read_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign SCLK           = sclk_q;
   assign cs_n           = cs_n_q;
   assign MOSI           = mosi_q;
   assign host.data_read = data_read_q;
   assign host.busy      = busy_q;
   assign host.done      = done_q;
   assign host.err       = err_q;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (DATA_W=8, NUM_SLAVES=3, CLK_DIV=2) with a
// behavioural SPI slave that drives MISO and reassembles MOSI.
module tb_spi_master_core;
   localparam int MAX_CYC = 200;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       MISO  = 1'b0;
   logic       SCLK;
   logic       MOSI;
   logic [2:0] cs_n;

   int n_cmp = 0;
   int n_bad = 0;

   spi_master_core_if #(.DATA_W(8), .NUM_SLAVES(3)) bus ();

   spi_master_core #(.DATA_W(8), .NUM_SLAVES(3), .CLK_DIV(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (bus),
      .MISO  (MISO),
      .SCLK  (SCLK),
      .cs_n  (cs_n),
      .MOSI  (MOSI)
   );

   always #5 clk = ~clk;

   // Slave model, evaluated on the falling system clock (away from DUT edges).
   logic [7:0] slv_tx      = 8'h00;
   logic [7:0] slv_rx_word = 8'h00;
   logic       slv_cpol    = 1'b0;
   logic       slv_cpha    = 1'b0;
   logic       slv_lsb     = 1'b0;
   logic       slv_first   = 1'b0;
   int         slv_idx     = 0;
   int         slv_cap     = 0;
   logic       sel_prev    = 1'b1;
   logic       sclk_prev   = 1'b0;
   wire        sel_n       = &cs_n;

   function automatic logic slv_bit(input logic [7:0] w, input logic lsb, input int i);
      return lsb ? w[i] : w[7-i];
   endfunction

   always @(negedge clk) begin
      logic lead;
      if (sel_prev && !sel_n) begin
         slv_idx = 0;
         slv_cap = 0;
         slv_rx_word = 8'h00;
         if (!slv_cpha) begin
            MISO = slv_bit(slv_tx, slv_lsb, 0);
            slv_idx = 1;
         end else begin
            MISO = 1'b0;
         end
      end else if (!sel_n && (SCLK !== sclk_prev)) begin
         lead = (SCLK != slv_cpol);
         if (lead != slv_cpha) begin
            if (slv_cap == 0) slv_first = MOSI;
            slv_rx_word = slv_lsb ? {MOSI, slv_rx_word[7:1]} : {slv_rx_word[6:0], MOSI};
            slv_cap++;
         end else if (slv_idx < 8) begin
            MISO = slv_bit(slv_tx, slv_lsb, slv_idx);
            slv_idx++;
         end
      end
      sel_prev  = sel_n;
      sclk_prev = SCLK;
   end

   // Called on a falling clock; returns on the falling clock where done is seen.
   task automatic do_xfer(input logic [7:0] wdata, input logic [1:0] addr,
                          input logic m_cpol, input logic m_cpha, input logic m_lsb,
                          input logic [7:0] sword, input int inj,
                          output int cyc, output int edges,
                          output logic [2:0] cs_seen, output logic sclk_first);
      logic sp;
      slv_tx = sword; slv_cpol = m_cpol; slv_cpha = m_cpha; slv_lsb = m_lsb;
      bus.data_write = wdata; bus.slave_address = addr;
      bus.cpol = m_cpol; bus.cpha = m_cpha; bus.lsb_first = m_lsb;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = -1; edges = 0; cs_seen = 3'b111; sclk_first = 1'b0; sp = 1'b0;
      for (int k = 1; k <= MAX_CYC; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) begin
            cs_seen = cs_n; sclk_first = SCLK; sp = SCLK;
         end else if (SCLK !== sp) begin
            edges++; sp = SCLK;
         end
         if (inj > 0 && k == inj) begin
            bus.start = 1'b1; bus.data_write = ~wdata;
            bus.slave_address = 2'd2; bus.cpol = ~m_cpol;
         end
         if (inj > 0 && k == inj + 1) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.data_write = 8'h00; bus.slave_address = 2'd0;
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (cs_n !== 3'b111) begin $display("FAIL reset_cs_n: got %b expected %b", cs_n, 3'b111); n_bad++; end
      n_cmp++; if (SCLK !== 1'b0) begin $display("FAIL reset_sclk: got %b expected 0", SCLK); n_bad++; end
      n_cmp++; if (MOSI !== 1'b0) begin $display("FAIL reset_mosi: got %b expected 0", MOSI); n_bad++; end
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bus.busy); n_bad++; end
      n_cmp++; if (bus.done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", bus.done); n_bad++; end
      n_cmp++; if (bus.err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", bus.err); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h00) begin $display("FAIL reset_data_read: got %h expected 00", bus.data_read); n_bad++; end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mode0();
      int cyc, edges; logic [2:0] cs_seen; logic sf;
      do_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, cyc, edges, cs_seen, sf);
      n_cmp++; if (cyc !== 37) begin $display("FAIL mode0_done_cycle: got %0d expected 37", cyc); n_bad++; end
      n_cmp++; if (edges !== 16) begin $display("FAIL mode0_sclk_edges: got %0d expected 16", edges); n_bad++; end
      n_cmp++; if (cs_seen !== 3'b110) begin $display("FAIL mode0_cs_n: got %b expected 110", cs_seen); n_bad++; end
      n_cmp++; if (sf !== 1'b0) begin $display("FAIL mode0_sclk_idle: got %b expected 0", sf); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h3C) begin $display("FAIL mode0_data_read: got %h expected 3c", bus.data_read); n_bad++; end
      n_cmp++; if (slv_rx_word !== 8'hA5) begin $display("FAIL mode0_mosi_word: got %h expected a5", slv_rx_word); n_bad++; end
      n_cmp++; if (slv_first !== 1'b1) begin $display("FAIL mode0_first_mosi: got %b expected 1", slv_first); n_bad++; end
      n_cmp++; if (cs_n !== 3'b111) begin $display("FAIL mode0_cs_release: got %b expected 111", cs_n); n_bad++; end
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL mode0_busy_at_done: got %b expected 0", bus.busy); n_bad++; end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin $display("FAIL mode0_done_width: got %b expected 0", bus.done); n_bad++; end
   endtask

   task automatic test_mode3_lsb();
      int cyc, edges; logic [2:0] cs_seen; logic sf;
      do_xfer(8'h01, 2'd2, 1'b1, 1'b1, 1'b1, 8'h80, 0, cyc, edges, cs_seen, sf);
      n_cmp++; if (cyc !== 37) begin $display("FAIL mode3_done_cycle: got %0d expected 37", cyc); n_bad++; end
      n_cmp++; if (edges !== 16) begin $display("FAIL mode3_sclk_edges: got %0d expected 16", edges); n_bad++; end
      n_cmp++; if (cs_seen !== 3'b011) begin $display("FAIL mode3_cs_n: got %b expected 011", cs_seen); n_bad++; end
      n_cmp++; if (sf !== 1'b1) begin $display("FAIL mode3_sclk_setup: got %b expected 1", sf); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h80) begin $display("FAIL mode3_data_read: got %h expected 80", bus.data_read); n_bad++; end
      n_cmp++; if (slv_first !== 1'b1) begin $display("FAIL mode3_first_mosi: got %b expected 1", slv_first); n_bad++; end
      n_cmp++; if (slv_rx_word !== 8'h01) begin $display("FAIL mode3_mosi_word: got %h expected 01", slv_rx_word); n_bad++; end
      repeat (2) @(negedge clk);
      n_cmp++; if (SCLK !== 1'b1) begin $display("FAIL mode3_sclk_idle: got %b expected 1", SCLK); n_bad++; end
   endtask

   task automatic test_bad_addr();
      logic sp; int toggles, cs_low, err_hi, busy_hi;
      sp = SCLK; toggles = 0; cs_low = 0; err_hi = 0; busy_hi = 0;
      bus.slave_address = 2'd3; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.err !== 1'b1) begin $display("FAIL badaddr_err: got %b expected 1", bus.err); n_bad++; end
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL badaddr_busy: got %b expected 0", bus.busy); n_bad++; end
      n_cmp++; if (cs_n !== 3'b111) begin $display("FAIL badaddr_cs_n: got %b expected 111", cs_n); n_bad++; end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (SCLK !== sp) toggles++;
         if (cs_n !== 3'b111) cs_low++;
         if (bus.err !== 1'b0) err_hi++;
         if (bus.busy !== 1'b0) busy_hi++;
      end
      n_cmp++; if (toggles !== 0) begin $display("FAIL badaddr_sclk: got %0d toggles expected 0", toggles); n_bad++; end
      n_cmp++; if (err_hi !== 0) begin $display("FAIL badaddr_err_width: got %0d extra cycles expected 0", err_hi); n_bad++; end
      n_cmp++; if (cs_low + busy_hi !== 0) begin $display("FAIL badaddr_idle: got %0d active cycles expected 0", cs_low + busy_hi); n_bad++; end
   endtask

   task automatic test_ignore_start();
      int cyc, edges, extra_done, extra_busy; logic [2:0] cs_seen; logic sf;
      do_xfer(8'h5A, 2'd1, 1'b0, 1'b0, 1'b0, 8'hC3, 10, cyc, edges, cs_seen, sf);
      n_cmp++; if (cyc !== 37) begin $display("FAIL ignore_done_cycle: got %0d expected 37", cyc); n_bad++; end
      n_cmp++; if (cs_seen !== 3'b101) begin $display("FAIL ignore_cs_n: got %b expected 101", cs_seen); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'hC3) begin $display("FAIL ignore_data_read: got %h expected c3", bus.data_read); n_bad++; end
      n_cmp++; if (slv_rx_word !== 8'h5A) begin $display("FAIL ignore_mosi_word: got %h expected 5a", slv_rx_word); n_bad++; end
      extra_done = 0; extra_busy = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) extra_done++;
         if (bus.busy !== 1'b0) extra_busy++;
      end
      n_cmp++; if (extra_done !== 0) begin $display("FAIL ignore_extra_done: got %0d expected 0", extra_done); n_bad++; end
      n_cmp++; if (extra_busy !== 0) begin $display("FAIL ignore_queued_start: got %0d busy cycles expected 0", extra_busy); n_bad++; end
   endtask

   task automatic test_reset_mid();
      int cyc, edges, seen, done_hi; logic [2:0] cs_seen; logic sf, sp;
      slv_tx = 8'h0F; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0;
      bus.data_write = 8'h33; bus.slave_address = 2'd0;
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      sp = SCLK; seen = 0;
      for (int k = 0; k < 100 && seen < 5; k++) begin
         @(negedge clk);
         if (SCLK !== sp) begin seen++; sp = SCLK; end
      end
      n_cmp++; if (seen !== 5) begin $display("FAIL rstmid_reach_edge5: got %0d expected 5", seen); n_bad++; end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (cs_n !== 3'b111) begin $display("FAIL rstmid_cs_n: got %b expected 111", cs_n); n_bad++; end
      n_cmp++; if (SCLK !== 1'b0) begin $display("FAIL rstmid_sclk: got %b expected 0", SCLK); n_bad++; end
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b expected 0", bus.busy); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h00) begin $display("FAIL rstmid_data_read: got %h expected 00", bus.data_read); n_bad++; end
      done_hi = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) done_hi++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) done_hi++;
      end
      n_cmp++; if (done_hi !== 0) begin $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_hi); n_bad++; end
      do_xfer(8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 8'h55, 0, cyc, edges, cs_seen, sf);
      n_cmp++; if (cyc !== 37) begin $display("FAIL rstmid_next_done_cycle: got %0d expected 37", cyc); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h55) begin $display("FAIL rstmid_next_data_read: got %h expected 55", bus.data_read); n_bad++; end
      n_cmp++; if (slv_rx_word !== 8'hFF) begin $display("FAIL rstmid_next_mosi_word: got %h expected ff", slv_rx_word); n_bad++; end
      n_cmp++; if (cs_seen !== 3'b110) begin $display("FAIL rstmid_next_cs_n: got %b expected 110", cs_seen); n_bad++; end
   endtask

   task automatic test_back_to_back();
      int d1, d2, hi; logic [7:0] rd1, w1;
      slv_tx = 8'h96; slv_cpol = 1'b0; slv_cpha = 1'b0; slv_lsb = 1'b0;
      bus.data_write = 8'h3C; bus.slave_address = 2'd1;
      bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      d1 = -1; d2 = -1; hi = 0; rd1 = 8'h00; w1 = 8'h00;
      for (int k = 1; k <= MAX_CYC; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (d1 < 0) begin
               d1 = k; rd1 = bus.data_read; w1 = slv_rx_word;
               slv_tx = 8'h69; bus.data_write = 8'hE7;
            end else begin
               d2 = k; bus.start = 1'b0;
               break;
            end
         end
         if (d1 >= 0 && cs_n === 3'b111) hi++;
      end
      bus.start = 1'b0;
      n_cmp++; if (d1 !== 37) begin $display("FAIL b2b_first_done: got %0d expected 37", d1); n_bad++; end
      n_cmp++; if (d2 !== 75) begin $display("FAIL b2b_second_done: got %0d expected 75", d2); n_bad++; end
      n_cmp++; if (hi !== 1) begin $display("FAIL b2b_cs_gap: got %0d cycles expected 1", hi); n_bad++; end
      n_cmp++; if (rd1 !== 8'h96) begin $display("FAIL b2b_first_read: got %h expected 96", rd1); n_bad++; end
      n_cmp++; if (w1 !== 8'h3C) begin $display("FAIL b2b_first_mosi: got %h expected 3c", w1); n_bad++; end
      n_cmp++; if (bus.data_read !== 8'h69) begin $display("FAIL b2b_second_read: got %h expected 69", bus.data_read); n_bad++; end
      n_cmp++; if (slv_rx_word !== 8'hE7) begin $display("FAIL b2b_second_mosi: got %h expected e7", slv_rx_word); n_bad++; end
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL b2b_no_third: got %b expected 0", bus.busy); n_bad++; end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3_lsb();
      test_bad_addr();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
